// File: rtl/qhv_arbiter.sv
// Query-HV arbiter: picks one of NumReq requesters and holds its HV toward the AM until accepted.
// Define QHV_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of the default round-robin.
module qhv_arbiter #(
  parameter int HVDimension = 512,
  parameter int NumReq      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clr_i,
  input  logic [NumReq*HVDimension-1:0] req_hv_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic                          am_busy_i,
  output logic [HVDimension-1:0]        qhv_o,
  output logic                          qhv_valid_o,
  input  logic                          qhv_ready_i,
  output logic [((NumReq > 1) ? $clog2(NumReq) : 1)-1:0] grant_id_o,
  output logic                          busy_o
);

  localparam int IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [IdW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]         grant_id_q, grant_id_d;
  logic [HVDimension-1:0] qhv_q, qhv_d;
  logic [IdW-1:0]         start, winner, idx;
  logic                   found, grant;
  int                     pos;

  // Search from the start pointer upward, wrapping at NumReq (works for non-power-of-two counts).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    pos    = 0;
    start  = rr_ptr_q;
    for (int i = 0; i < NumReq; i++) begin
      pos = int'(start) + i;
      if (pos >= NumReq) pos = pos - NumReq;
      idx = IdW'(pos);
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign grant = (state_q == IDLE) && found && !am_busy_i && !clr_i && !rst_i;

  always_comb begin
    req_ready_o = '0;
    if (grant) req_ready_o[winner] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    qhv_d      = qhv_q;
    if (clr_i) begin
      state_d    = IDLE;
      grant_id_d = '0;
      qhv_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_d    = HOLD;
            grant_id_d = winner;
            qhv_d      = req_hv_i[int'(winner)*HVDimension +: HVDimension];
`ifdef QHV_ARB_FIXED_PRIO_EN
            rr_ptr_d   = '0;
`else
            rr_ptr_d   = (winner == IdW'(NumReq - 1)) ? '0 : winner + IdW'(1);
`endif
          end
        end
        HOLD: begin
          // The handshake edge only returns to IDLE; the next grant waits a cycle.
          if (qhv_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      qhv_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      qhv_q      <= qhv_d;
    end
  end

  assign qhv_o       = qhv_q;
  assign grant_id_o  = grant_id_q;
  assign qhv_valid_o = (state_q == HOLD);
  assign busy_o      = (state_q == HOLD) && !rst_i;

endmodule

// File: tb/tb_qhv_arbiter.sv
// Directed bench for qhv_arbiter (NumReq=4, HVDimension=512); honours QHV_ARB_FIXED_PRIO_EN.
module tb_qhv_arbiter;

  localparam int HV = 512;
  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           rst_i, clr_i, am_busy_i, qhv_ready_i;
  logic [NR*HV-1:0] req_hv_i;
  logic [NR-1:0]  req_valid_i, req_ready_o;
  logic [HV-1:0]  qhv_o;
  logic           qhv_valid_o, busy_o;
  logic [1:0]     grant_id_o;

  logic [HV-1:0]  hv [NR];
  int             errors = 0;
  int             checks = 0;
  int             exp_id;

  qhv_arbiter #(.HVDimension(HV), .NumReq(NR)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .req_hv_i(req_hv_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .am_busy_i(am_busy_i),
    .qhv_o(qhv_o), .qhv_valid_o(qhv_valid_o), .qhv_ready_i(qhv_ready_i),
    .grant_id_o(grant_id_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [HV-1:0] obs, input logic [HV-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    hv[0] = {64{8'h11}};
    hv[1] = {64{8'h22}};
    hv[2] = {64{8'hA5}};
    hv[3] = {64{8'h3C}};
    for (int k = 0; k < NR; k++) req_hv_i[k*HV +: HV] = hv[k];
    rst_i = 1'b1; clr_i = 1'b0; am_busy_i = 1'b0; qhv_ready_i = 1'b0; req_valid_i = '0;

    // Reset: ready and busy held low while rst_i is high
    tick(); tick();
    req_valid_i = 4'b1111;
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    req_valid_i = '0;
    rst_i = 1'b0;
    tick();
    chk("rst_qhv_valid", qhv_valid_o, 0);
    chk("rst_qhv", qhv_o, 0);
    chk("rst_gid", grant_id_o, 0);
    chk("rst_busy_after", busy_o, 0);

    // Single request from requester 2
    req_valid_i = 4'b0100;
    #1;
    chk("r2_ready", req_ready_o, 4'b0100);
    tick();
    req_valid_i = '0;
    chk("r2_valid", qhv_valid_o, 1);
    chk("r2_qhv", qhv_o, hv[2]);
    chk("r2_gid", grant_id_o, 2);
    chk("r2_busy", busy_o, 1);
    qhv_ready_i = 1'b1;
    tick();
    qhv_ready_i = 1'b0;
    chk("r2_done_valid", qhv_valid_o, 0);
    chk("r2_qhv_kept", qhv_o, hv[2]);

    // Pointer at 3, requesters 0 and 1: wrap to 0, then 1
    req_valid_i = 4'b0011;
    #1;
    chk("wrap_ready0", req_ready_o, 4'b0001);
    tick();
    req_valid_i = 4'b0010;
    chk("wrap_gid0", grant_id_o, 0);
    chk("wrap_qhv0", qhv_o, hv[0]);
    qhv_ready_i = 1'b1;
    #1;
    chk("wrap_hold_ready", req_ready_o, 0);
    tick();
    qhv_ready_i = 1'b0;
    #1;
    chk("wrap_ready1", req_ready_o, 4'b0010);
    tick();
    req_valid_i = '0;
    chk("wrap_gid1", grant_id_o, 1);
    qhv_ready_i = 1'b1;
    tick();
    qhv_ready_i = 1'b0;

    // All requesting with AM always ready: one grant every two cycles
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    req_valid_i = 4'b1111;
    qhv_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
`ifdef QHV_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = (c / 2) % NR;
`endif
      #1;
      if (c % 2 == 0) begin
        chk($sformatf("rr_ready_c%0d", c), req_ready_o, 4'b0001 << exp_id);
      end else begin
        chk($sformatf("rr_ready_c%0d", c), req_ready_o, 0);
        chk($sformatf("rr_gid_c%0d", c), grant_id_o, exp_id);
        chk($sformatf("rr_qhv_c%0d", c), qhv_o, hv[exp_id]);
      end
      tick();
    end
    req_valid_i = '0;
    qhv_ready_i = 1'b0;

    // AM busy blocks grants; grant on the first cycle after it falls
    am_busy_i = 1'b1;
    req_valid_i = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("ambusy_ready_c%0d", c), req_ready_o, 0);
      tick();
    end
    am_busy_i = 1'b0;
    #1;
    chk("ambusy_grant", req_ready_o, 4'b0001);
    tick();
    chk("ambusy_gid", grant_id_o, 0);
    chk("ambusy_qhv", qhv_o, hv[0]);
    chk("ambusy_valid", qhv_valid_o, 1);

    // Long HOLD: outputs stable, no ready even with all requesting
    req_valid_i = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("hold_ready_c%0d", c), req_ready_o, 0);
      chk($sformatf("hold_qhv_c%0d", c), qhv_o, hv[0]);
      chk($sformatf("hold_gid_c%0d", c), grant_id_o, 0);
      chk($sformatf("hold_valid_c%0d", c), qhv_valid_o, 1);
      tick();
    end

    // Clear together with the AM handshake
    clr_i = 1'b1;
    qhv_ready_i = 1'b1;
    #1;
    chk("clr_hold_ready", req_ready_o, 0);
    tick();
    qhv_ready_i = 1'b0;
    chk("clr_valid", qhv_valid_o, 0);
    chk("clr_qhv", qhv_o, 0);
    chk("clr_gid", grant_id_o, 0);
    chk("clr_busy", busy_o, 0);
    #1;
    chk("clr_idle_ready", req_ready_o, 0);
    tick();
    clr_i = 1'b0;
`ifdef QHV_ARB_FIXED_PRIO_EN
    exp_id = 0;
`else
    exp_id = 1;
`endif
    #1;
    chk("clr_ptr_ready", req_ready_o, 4'b0001 << exp_id);
    tick();
    req_valid_i = '0;
    chk("clr_ptr_gid", grant_id_o, exp_id);
    chk("clr_ptr_qhv", qhv_o, hv[exp_id]);

    // Reset during HOLD drops the query
    rst_i = 1'b1;
    #1;
    chk("rsthold_busy", busy_o, 0);
    chk("rsthold_ready", req_ready_o, 0);
    tick();
    rst_i = 1'b0;
    chk("rsthold_valid", qhv_valid_o, 0);
    chk("rsthold_qhv", qhv_o, 0);
    chk("rsthold_gid", grant_id_o, 0);
    chk("rsthold_busy_after", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qhv_arbiter.md
QHV_ARBITER -- requirements
Module: qhv_arbiter

Interface
REQ-001 SHALL have parameter HVDimension, default 512, meaning the query hypervector width in bits.
REQ-002 SHALL have parameter NumReq, default 4, meaning the number of query requesters (legal range 2..16).
REQ-003 SHALL have port clk_i, input, 1, single clock, all logic rising-edge.
REQ-004 SHALL have port rst_i, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port clr_i, input, 1, synchronous soft clear.
REQ-006 SHALL have port req_hv_i, input, NumReq*HVDimension, requester k's HV at bits [k*HVDimension +: HVDimension].
REQ-007 SHALL have port req_valid_i, input, NumReq, per-requester request.
REQ-008 SHALL have port req_ready_o, output, NumReq, per-requester accept.
REQ-009 SHALL have port am_busy_i, input, 1, associative memory busy; blocks new grants.
REQ-010 SHALL have port qhv_o, output, HVDimension, registered query HV to the AM.
REQ-011 SHALL have port qhv_valid_o, output, 1, query HV valid toward the AM.
REQ-012 SHALL have port qhv_ready_i, input, 1, AM accepts query.
REQ-013 SHALL have port grant_id_o, output, max(1,$clog2(NumReq)), index of the requester whose HV is in qhv_o.
REQ-014 SHALL have port busy_o, output, 1, high whenever the FSM is not IDLE.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and HOLD.
REQ-016 IDLE: when any req_valid_i bit is high, am_busy_i=0 and clr_i=0, SHALL select one winner and assert req_ready_o[winner] combinationally in that same cycle, with all other ready bits 0.
REQ-017 On that grant edge SHALL load qhv_o from the winner's slice and grant_id_o with the winner index, set qhv_valid_o=1, and go to HOLD.
REQ-018 Latency: request accepted in cycle N -> qhv_valid_o high in cycle N+1.
REQ-019 HOLD: all req_ready_o=0; qhv_o and grant_id_o stable; when qhv_ready_i=1 SHALL clear qhv_valid_o and return to IDLE on that edge.
REQ-020 A new grant SHALL NOT be issued in the same cycle as the AM handshake, so peak throughput is one query per 2 cycles.
REQ-021 am_busy_i=1 in IDLE SHALL suppress all req_ready_o; am_busy_i in HOLD SHALL have no effect.
REQ-022 Round-robin: the search SHALL start at pointer rr_ptr and ascend with wrap NumReq-1 -> 0; on a grant rr_ptr SHALL become (winner+1) mod NumReq, including non-power-of-two NumReq.
REQ-023 A requester deasserting valid before being granted SHALL be ignored without error; requesters SHALL hold valid and data until ready.
REQ-024 clr_i SHALL have top priority: no ready that cycle; next cycle FSM=IDLE, qhv_valid_o=0, qhv_o=0, grant_id_o=0; rr_ptr unchanged.
REQ-025 clr_i and qhv_ready_i together SHALL behave as clr_i alone.
REQ-026 qhv_o SHALL change only on grant or clear/reset.

Reset
REQ-027 rst_i=1 at a rising edge SHALL force FSM=IDLE, rr_ptr=0, qhv_o=0, qhv_valid_o=0, grant_id_o=0.
REQ-028 While rst_i=1, req_ready_o SHALL be 0 and busy_o SHALL be 0.
REQ-029 Reset mid-HOLD SHALL drop the pending query without handshake.
REQ-030 rst_i SHALL take priority over clr_i.

Configuration
REQ-031 Macro QHV_ARB_FIXED_PRIO_EN: when defined, the winner SHALL be the lowest-index valid requester, and rr_ptr SHALL be absent or held at 0.
REQ-032 Macro QHV_ARB_FIXED_PRIO_EN: when undefined, the arbiter SHALL use round-robin per REQ-022 (default build).

Verification (NumReq=4, HVDimension=512)
REQ-033 Reset, then req_valid_i=4'b0100, HV2=all-0xA5 -> req_ready_o=4'b0100 same cycle; next cycle qhv_valid_o=1, qhv_o=0xA5.., grant_id_o=2.
REQ-034 req_valid_i=4'b1111 held, qhv_ready_i=1 -> grant order 0,1,2,3,0 on cycles 0,2,4,6,8; with QHV_ARB_FIXED_PRIO_EN the order is 0,0,0,...
REQ-035 rr_ptr=3 and req_valid_i=4'b0011 -> grant 0, then grant 1 (wrap).
REQ-036 am_busy_i=1 for 5 cycles with req_valid_i=4'b0001 -> req_ready_o=0 throughout; grant in the first cycle after am_busy_i falls.
REQ-037 HOLD with qhv_ready_i=0 for 10 cycles -> qhv_o and grant_id_o stable, no ready issued; clr_i=1 with qhv_ready_i=1 -> next cycle qhv_valid_o=0, qhv_o=0, rr_ptr preserved.
REQ-038 rst_i asserted during HOLD -> next cycle all outputs are reset values and busy_o=0.
